// File: rtl/oscilo_uart_pkg.sv
// Shared opcodes, reply codes and FSM state type
// for the UART command responder.
package oscilo_uart_pkg;

  localparam logic [7:0] OP_ID  = 8'h3F;
  localparam logic [7:0] OP_RD  = 8'h52;
  localparam logic [7:0] OP_WR  = 8'h57;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    SEND,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/uart_cmd_responder.sv
// Byte-level command parser for the UART link:
// identify, register read and register write.
module uart_cmd_responder
  import oscilo_uart_pkg::*;
#(
  parameter int          TIMEOUT_CLKS = 8680,
  parameter logic [31:0] ID_WORD      = 32'h4F534331
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic [31:0] regs,
  output logic        busy,
  output logic        overrun
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  state_t      state;
  logic [7:0]  opcode;
  logic [7:0]  addr;
  logic [7:0]  data;
  logic [23:0] reply_buf;
  logic [1:0]  pend;
  logic [TW-1:0] tmo_cnt;
  logic        addr_ok;
  logic        replying;

  assign addr_ok  = (addr[7:2] == 6'd0);
  assign busy     = (state != IDLE);
  assign replying = (state == EXEC) ||
                    (state == SEND) ||
                    (state == WAIT_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opcode    <= 8'h00;
      addr      <= 8'h00;
      data      <= 8'h00;
      reply_buf <= 24'h0;
      pend      <= 2'd0;
      tmo_cnt   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      regs      <= 32'h0;
      overrun   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (rx_valid && replying)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (rx_valid) begin
            opcode <= rx_data;
            if (rx_data == OP_RD || rx_data == OP_WR)
              state <= GET_ADDR;
            else
              state <= EXEC;
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            addr    <= rx_data;
            tmo_cnt <= '0;
            if (opcode == OP_WR)
              state <= GET_DATA;
            else
              state <= EXEC;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            data    <= rx_data;
            tmo_cnt <= '0;
            state   <= EXEC;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt <= '0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        EXEC: begin
          state     <= SEND;
          tx_start  <= 1'b1;
          pend      <= 2'd0;
          reply_buf <= 24'h0;
          unique case (1'b1)
            opcode == OP_ID: begin
              tx_data   <= ID_WORD[31:24];
              reply_buf <= ID_WORD[23:0];
              pend      <= 2'd3;
            end
            (opcode == OP_RD) && addr_ok: begin
              tx_data <= regs[{addr[1:0], 3'b000} +: 8];
            end
            (opcode == OP_WR) && addr_ok: begin
              regs[{addr[1:0], 3'b000} +: 8] <= data;
              tx_data <= RSP_ACK;
            end
            default: begin
              tx_data <= RSP_NAK;
            end
          endcase
        end
        SEND: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (pend != 2'd0) begin
              tx_data   <= reply_buf[23:16];
              reply_buf <= {reply_buf[15:0], 8'h00};
              pend      <= pend - 2'd1;
              tx_start  <= 1'b1;
              state     <= SEND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder with
// a behavioural uart_tx responder model.
module tb_uart_cmd_responder;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [31:0] regs;
  logic        busy;
  logic        overrun;

  logic [7:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_started = 0;
  logic outstanding;
  logic [7:0] cur;
  int dly;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .TIMEOUT_CLKS(TMO),
    .ID_WORD(32'h4F534331)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_done(tx_done),
    .regs(regs),
    .busy(busy),
    .overrun(overrun)
  );

  // uart_tx stand-in: scores each started byte, answers with tx_done
  initial begin
    logic [7:0] exp;
    tx_done = 1'b0;
    outstanding = 1'b0;
    cur = 8'h00;
    dly = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) begin
        outstanding = 1'b0;
      end else if (tx_start) begin
        n_started++;
        n_checks++;
        if (outstanding) begin
          n_fail++;
          $display("FAIL tx_overlap: tx_start=1 required 0 (byte %h pending)", cur);
        end
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got %h required no tx_start", tx_data);
        end else begin
          exp = sb.pop_front();
          if (tx_data !== exp) begin
            n_fail++;
            $display("FAIL tx_byte: got %h required %h", tx_data, exp);
          end
        end
        outstanding = 1'b1;
        cur = tx_data;
        dly = $urandom_range(1, 4);
      end else if (outstanding) begin
        if (dly == 0) begin
          n_checks++;
          if (tx_data !== cur) begin
            n_fail++;
            $display("FAIL tx_hold: got %h required %h", tx_data, cur);
          end
          tx_done = 1'b1;
          outstanding = 1'b0;
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || sb.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 500) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%b pending=%0d required idle", name, busy, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic push_id();
    sb.push_back(8'h4F);
    sb.push_back(8'h53);
    sb.push_back(8'h43);
    sb.push_back(8'h31);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_tx_start: got %b required 0", tx_start);
    end
    if (tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_tx_data: got %h required 00", tx_data);
    end
    if (regs !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_regs: got %h required 0", regs);
    end
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b required 0", busy);
    end
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_overrun: got %b required 0", overrun);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_id();
    int s = n_started;
    push_id();
    send_byte(8'h3F);
    n_checks += 2;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL id_busy: got %b required 1", busy);
    end
    @(negedge clk);
    if (tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL id_latency: tx_start=%b required 1", tx_start);
    end
    wait_idle("id");
    n_checks += 3;
    if (n_started != s + 4) begin
      n_fail++;
      $display("FAIL id_count: got %0d required 4", n_started - s);
    end
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL id_busy_end: got %b required 0", busy);
    end
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL id_overrun: got %b required 0", overrun);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] v[4];
    v[0] = 8'h3C;
    v[1] = 8'h81;
    v[2] = 8'hA5;
    v[3] = 8'h7E;
    sb.push_back(8'h06);
    send_byte(8'h57);
    send_byte(8'h02);
    send_byte(8'hA5);
    wait_idle("wr2");
    n_checks++;
    if (regs !== 32'h00A50000) begin
      n_fail++;
      $display("FAIL wr2_regs: got %h required 00a50000", regs);
    end
    sb.push_back(8'hA5);
    send_byte(8'h52);
    send_byte(8'h02);
    wait_idle("rd2");
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        sb.push_back(8'h06);
        send_byte(8'h57);
        send_byte(8'(i));
        send_byte(v[i]);
        wait_idle("wr");
      end
    end
    for (int i = 3; i >= 0; i--) begin
      sb.push_back(v[i]);
      send_byte(8'h52);
      send_byte(8'(i));
      wait_idle("rd");
    end
    n_checks++;
    if (regs !== {v[3], v[2], v[1], v[0]}) begin
      n_fail++;
      $display("FAIL wr_all_regs: got %h required %h", regs, {v[3], v[2], v[1], v[0]});
    end
  endtask

  task automatic test_nak();
    logic [31:0] r = regs;
    sb.push_back(8'h15);
    send_byte(8'h52);
    send_byte(8'h07);
    wait_idle("rd_bad");
    sb.push_back(8'h15);
    send_byte(8'h00);
    wait_idle("bad_op");
    sb.push_back(8'h15);
    send_byte(8'h57);
    send_byte(8'h04);
    send_byte(8'hFF);
    wait_idle("wr_bad");
    n_checks++;
    if (regs !== r) begin
      n_fail++;
      $display("FAIL nak_regs: got %h required %h", regs, r);
    end
  endtask

  task automatic test_slow_bytes();
    sb.push_back(8'h06);
    send_byte(8'h57);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h03);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h5A);
    wait_idle("slow");
    n_checks++;
    if (regs[31:24] !== 8'h5A) begin
      n_fail++;
      $display("FAIL slow_reg3: got %h required 5a", regs[31:24]);
    end
  endtask

  task automatic test_timeout();
    int s = n_started;
    logic [31:0] r = regs;
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (TMO + 1) @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_busy: got %b required 0", busy);
    end
    if (n_started != s) begin
      n_fail++;
      $display("FAIL tmo_tx: got %0d starts required 0", n_started - s);
    end
    if (regs !== r) begin
      n_fail++;
      $display("FAIL tmo_regs: got %h required %h", regs, r);
    end
    push_id();
    send_byte(8'h3F);
    wait_idle("tmo_id");
  endtask

  task automatic test_overrun();
    int s = n_started;
    push_id();
    send_byte(8'h3F);
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1;
      rx_data = 8'h55;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_flag: got %b required 1", overrun);
    end
    wait_idle("ovr");
    n_checks += 2;
    if (n_started != s + 4) begin
      n_fail++;
      $display("FAIL ovr_count: got %0d required 4", n_started - s);
    end
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b required 1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    int s = n_started;
    int k = 0;
    push_id();
    send_byte(8'h3F);
    while (n_started < s + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL rmid_wait: got %0d starts required 2", n_started - s);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_checks += 4;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_overrun: got %b required 0", overrun);
    end
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_busy: got %b required 0", busy);
    end
    if (tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_tx_start: got %b required 0", tx_start);
    end
    s = n_started;
    repeat (30) @(negedge clk);
    if (n_started != s) begin
      n_fail++;
      $display("FAIL rmid_quiet: got %0d starts required 0", n_started - s);
    end
    push_id();
    send_byte(8'h3F);
    wait_idle("rmid_id");
  endtask

  initial begin
    test_reset();
    test_id();
    test_write_read();
    test_nak();
    test_slow_bytes();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CLKS, default 8680, giving the max clocks between bytes of one command (20 bit-times at 434 clocks per bit).
REQ-002 SHALL have parameter ID_WORD, default 32'h4F534331 ("OSC1"), giving the identity reply, MSB byte first.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe marking a received byte from uart_rx.
REQ-006 SHALL have port rx_data  input  8  received byte, qualified by rx_valid.
REQ-007 SHALL have port tx_start  output  1  one-cycle pulse requesting uart_tx to send tx_data.
REQ-008 SHALL have port tx_data  output  8  reply byte, stable from tx_start until tx_done.
REQ-009 SHALL have port tx_done  input  1  one-cycle strobe from uart_tx marking byte complete.
REQ-010 SHALL have port regs  output  32  register file, reg n at bits [8n+7:8n], n=0..3.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port overrun  output  1  sticky flag: a byte arrived while replying.

Function
REQ-013 SHALL implement states IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_DONE.
REQ-014 IDLE + rx_valid: 0x3F ('?') -> EXEC; 0x52 ('R') or 0x57 ('W') -> GET_ADDR with opcode latched; any other byte -> EXEC with a NAK (0x15) reply.
REQ-015 GET_ADDR + rx_valid: latch addr; 'R' -> EXEC, 'W' -> GET_DATA.
REQ-016 GET_DATA + rx_valid: latch data -> EXEC.
REQ-017 EXEC SHALL take one cycle and build the reply: '?' -> the 4 ID_WORD bytes; 'R' with addr<4 -> regs byte addr; 'W' with addr<4 -> write reg addr with data in this cycle, reply ACK 0x06; addr>=4 -> NAK 0x15 with no write.
REQ-018 SEND SHALL pulse tx_start for exactly one cycle with tx_data valid, then go to WAIT_DONE.
REQ-019 WAIT_DONE + tx_done: more bytes pending -> SEND (next byte); otherwise -> IDLE.
REQ-020 SHALL never assert tx_start while a previously started byte lacks its tx_done.
REQ-021 Latency: first tx_start SHALL occur 2 cycles after the rx_valid that completes the command.
REQ-022 Timeout counter SHALL clear on every accepted byte and count in GET_ADDR/GET_DATA; reaching TIMEOUT_CLKS -> IDLE, no reply, no write.
REQ-023 rx_valid in EXEC/SEND/WAIT_DONE SHALL be dropped and set overrun; the reply in progress SHALL be unaffected.
REQ-024 overrun SHALL clear only on reset.
REQ-025 rx_valid and tx_done in the same cycle SHALL be handled per REQ-019 and REQ-023 independently.

Reset
REQ-026 On rst: state IDLE, tx_start=0, tx_data=0x00, regs=0, busy=0, overrun=0, timeout counter=0, all latches cleared.
REQ-027 Reset mid-reply SHALL abandon the remaining bytes; no tx_start SHALL follow reset until a new command completes.

Structure
REQ-028 Package oscilo_uart_pkg SHALL hold the opcode constants ('?', 'R', 'W'), ACK/NAK codes, and the state enum typedef.
REQ-029 SHALL be a single module with no sub-modules; uart_rx and uart_tx SHALL be instantiated by the parent, not inside this block.

Verification
REQ-030 rx_valid 0x3F -> tx_data 0x4F, 0x53, 0x43, 0x31 in order; each tx_start only after the prior tx_done; busy drops after the last done.
REQ-031 'W',0x02,0xA5 -> regs[23:16]=0xA5, reply 0x06; then 'R',0x02 -> reply 0xA5.
REQ-032 'R',0x07 -> reply 0x15, regs unchanged; single byte 0x00 -> reply 0x15.
REQ-033 'W',0x01 then idle TIMEOUT_CLKS+1 clocks -> no tx_start, busy=0; a following 0x3F is answered normally.
REQ-034 rx_valid 0x55 during the ID reply -> overrun=1, all 4 ID bytes still sent; rst after the 2nd byte -> tx_start stays low, overrun=0, state IDLE.
